pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline stage register for the five-stage MIPS core. It carries PC, delay-slot flag, exception code and an opaque payload between two pipeline stages using a valid/ready handshake. It supports bubble insertion that preserves metadata, and an exception-request flush that redirects the stage PC to the handler vector. It is the drop-in successor to the fixed-width, stall-driven stage registers, sitting between any two adjacent stages (D/E, E/M, M/W).

---
 rtl/pipe_stage_buf_if.sv | 15 +
 rtl/pipe_stage_buf.sv | 111 +++++++++++
 tb/tb_pipe_stage_buf.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready pipeline entry bus (pc, delay-slot flag, exception code, payload)
//   master: drives valid/pc/bd/exc/payload, samples ready
//   slave : samples valid/pc/bd/exc/payload, drives ready
interface pipe_stage_buf_if #(
  parameter int PAYLOAD_W = 128
);
  logic                 valid;
  logic                 ready;
  logic [31:0]          pc;
  logic                 bd;
  logic [4:0]           exc;
  logic [PAYLOAD_W-1:0] payload;
  modport master (output valid, pc, bd, exc, payload, input ready);
  modport slave  (input valid, pc, bd, exc, payload, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic MIPS pipeline stage register with bubble insertion and exception redirect
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset
//   i_req       : exception flush, loads a valid bubble at EXC_VECTOR (highest priority)
//   i_bubble    : accepted entry keeps pc/bd/exc but has its payload zeroed
//   i_up        : upstream entry bus (slave)
//   o_dn        : downstream entry bus (master)
//   o_occupancy : stored entries (0..2)
//   Macro PIPE_STAGE_BUF_SKID_EN: adds a skid register so in_ready is registered;
//   without it the stage holds one entry and in_ready is combinational.
module pipe_stage_buf #(
  parameter int          PAYLOAD_W  = 128,
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_bubble,
  pipe_stage_buf_if.slave   i_up,
  pipe_stage_buf_if.master  o_dn,
  output logic [1:0]        o_occupancy
);
`ifdef PIPE_STAGE_BUF_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif
  state_t               r_state, w_next;
  logic [31:0]          r_pc;
  logic                 r_bd;
  logic [4:0]           r_exc;
  logic [PAYLOAD_W-1:0] r_pay;
  logic                 w_accept, w_pop, w_ld_in;
  logic [PAYLOAD_W-1:0] w_in_pay;
  assign w_in_pay    = i_bubble ? '0 : i_up.payload;
  assign w_accept    = i_up.valid & i_up.ready;
  assign w_pop       = o_dn.valid & o_dn.ready;
  assign o_dn.valid  = r_state != EMPTY;
  assign o_dn.pc     = r_pc;
  assign o_dn.bd     = r_bd;
  assign o_dn.exc    = r_exc;
  assign o_dn.payload = r_pay;
  assign o_occupancy = r_state;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= EMPTY;
    else       r_state <= w_next;
`ifdef PIPE_STAGE_BUF_SKID_EN
  logic [31:0]          r_s_pc;
  logic                 r_s_bd;
  logic [4:0]           r_s_exc;
  logic [PAYLOAD_W-1:0] r_s_pay;
  logic                 w_ld_skid, w_from_skid;
  // ready depends only on the state register, never on out_ready
  assign i_up.ready  = r_state != TWO;
  assign w_ld_in     = w_accept & (r_state == EMPTY | (r_state == ONE & w_pop));
  assign w_ld_skid   = w_accept & r_state == ONE & ~w_pop;
  assign w_from_skid = w_pop & r_state == TWO;
  always_comb begin
    w_next = r_state;
    if (i_req | w_ld_in | w_from_skid) w_next = ONE;
    else if (w_ld_skid)                w_next = TWO;
    else if (w_pop)                    w_next = EMPTY;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset | i_req) begin
      r_s_pc  <= '0;
      r_s_bd  <= 1'b0;
      r_s_exc <= '0;
      r_s_pay <= '0;
    end else if (w_ld_skid) begin
      r_s_pc  <= i_up.pc;
      r_s_bd  <= i_up.bd;
      r_s_exc <= i_up.exc;
      r_s_pay <= w_in_pay;
    end
`else
  assign i_up.ready = ~o_dn.valid | o_dn.ready;
  assign w_ld_in    = w_accept;
  always_comb begin
    w_next = r_state;
    if (i_req | w_ld_in) w_next = ONE;
    else if (w_pop)      w_next = EMPTY;
  end
`endif
  // req overrides any same-cycle accept or pop
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pc  <= PC_RESET;
      r_bd  <= 1'b0;
      r_exc <= '0;
      r_pay <= '0;
    end else if (i_req) begin
      r_pc  <= EXC_VECTOR;
      r_bd  <= 1'b0;
      r_exc <= '0;
      r_pay <= '0;
    end else if (w_ld_in) begin
      r_pc  <= i_up.pc;
      r_bd  <= i_up.bd;
      r_exc <= i_up.exc;
      r_pay <= w_in_pay;
`ifdef PIPE_STAGE_BUF_SKID_EN
    end else if (w_from_skid) begin
      r_pc  <= r_s_pc;
      r_bd  <= r_s_bd;
      r_exc <= r_s_exc;
      r_pay <= r_s_pay;
`endif
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench for pipe_stage_buf (stream, backpressure, bubble, req, reset)
module tb_pipe_stage_buf;
  typedef struct packed {
    logic [31:0]  pc;
    logic         bd;
    logic [4:0]   exc;
    logic [127:0] pay;
  } ent_t;
`ifdef PIPE_STAGE_BUF_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam ent_t VEC = {32'h0000_4180, 1'b0, 5'd0, 128'd0};
  localparam ent_t RST = {32'h0000_3000, 1'b0, 5'd0, 128'd0};
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, bubble = 1'b0;
  logic [1:0] occ;
  pipe_stage_buf_if #(.PAYLOAD_W(128)) up();
  pipe_stage_buf_if #(.PAYLOAD_W(128)) dn();
  pipe_stage_buf #(.PAYLOAD_W(128)) dut (
    .clk(clk), .reset(reset), .i_req(req), .i_bubble(bubble),
    .i_up(up), .o_dn(dn), .o_occupancy(occ)
  );
  always #5 clk = ~clk;
  ent_t q[$];
  int   n_cmp = 0, n_bad = 0;
  logic s_acc, s_pop;
  ent_t s_out;
  function automatic ent_t mk(logic [31:0] pc);
    mk = {pc, 1'b0, 5'd0, {$urandom(), $urandom(), $urandom(), $urandom()}};
  endfunction
  function automatic ent_t stored(ent_t e, logic b);
    stored = e;
    if (b) stored.pay = '0;
  endfunction
  function automatic ent_t cur();
    cur = {dn.pc, dn.bd, dn.exc, dn.payload};
  endfunction
  task automatic drive(ent_t e, logic v);
    up.valid = v; up.pc = e.pc; up.bd = e.bd; up.exc = e.exc; up.payload = e.pay;
  endtask
  task automatic tick();
    @(negedge clk);
    s_acc = up.valid & up.ready;
    s_pop = dn.valid & dn.ready;
    s_out = cur();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(RST, 1'b0); dn.ready = 1'b0; req = 1'b0; bubble = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({dn.valid, up.ready, occ} !== 4'b0100) begin
      n_bad++; $display("FAIL reset_status got v=%b rdy=%b occ=%0d exp v=0 rdy=1 occ=0", dn.valid, up.ready, occ);
    end
    n_cmp++;
    if (cur() !== RST) begin
      n_bad++; $display("FAIL reset_fields got %h exp %h", cur(), RST);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    ent_t e[3], x;
    int npop = 0;
    e[0] = mk(32'h3000); e[1] = mk(32'h3004); e[2] = mk(32'h3008);
    dn.ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(e[c], 1'b1); else up.valid = 1'b0;
      tick();
      if (s_pop) begin
        npop++; n_cmp++; x = q.size() ? q.pop_front() : 'x;
        if (s_out !== x) begin n_bad++; $display("FAIL stream_pop got %h exp %h", s_out, x); end
      end
      if (s_acc) q.push_back(e[c]);
      if (c < 3) begin
        n_cmp++;
        if (!(s_acc === 1'b1 && dn.valid === 1'b1 && occ === 2'd1)) begin
          n_bad++; $display("FAIL stream_latency got acc=%b v=%b occ=%0d exp acc=1 v=1 occ=1", s_acc, dn.valid, occ);
        end
      end
    end
    n_cmp++;
    if (npop != 3 || q.size() != 0) begin
      n_bad++; $display("FAIL stream_count got pops=%0d left=%0d exp pops=3 left=0", npop, q.size());
    end
  endtask

  task automatic test_backpressure();
    ent_t e[3], x;
    int idx = 0, npop = 0;
    e[0] = mk(32'h3000); e[1] = mk(32'h3004); e[2] = mk(32'h3008);
    dn.ready = 1'b0;
    for (int c = 0; c < 40 && (idx < 3 || q.size() > 0); c++) begin
      if (c == 4) dn.ready = 1'b1;
      if (idx < 3) drive(e[idx], 1'b1); else up.valid = 1'b0;
      tick();
      if (s_pop) begin
        npop++; n_cmp++; x = q.size() ? q.pop_front() : 'x;
        if (s_out !== x) begin n_bad++; $display("FAIL bp_pop got %h exp %h", s_out, x); end
      end
      if (s_acc) begin q.push_back(e[idx]); idx++; end
      if (c == 0) begin
        n_cmp++;
        if (up.ready !== (CAP == 2)) begin
          n_bad++; $display("FAIL bp_ready_first got %b exp %b", up.ready, CAP == 2);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (idx != CAP || up.ready !== 1'b0 || occ !== 2'(CAP) || dn.pc !== 32'h3000) begin
          n_bad++; $display("FAIL bp_stalled got stored=%0d rdy=%b occ=%0d pc=%h exp stored=%0d rdy=0 occ=%0d pc=3000",
                            idx, up.ready, occ, dn.pc, CAP, CAP);
        end
      end
    end
    up.valid = 1'b0;
    n_cmp++;
    if (npop != 3 || q.size() != 0) begin
      n_bad++; $display("FAIL bp_count got pops=%0d left=%0d exp pops=3 left=0", npop, q.size());
    end
  endtask

  task automatic test_bubble();
    ent_t e[2], x;
    logic b[2];
    int npop = 0;
    e[0] = {32'h3010, 1'b1, 5'd4, {128{1'b1}}}; b[0] = 1'b1;
    e[1] = {32'h3014, 1'b1, 5'd9, {128{1'b1}}}; b[1] = 1'b0;
    dn.ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) begin drive(e[c], 1'b1); bubble = b[c]; end else begin up.valid = 1'b0; bubble = 1'b0; end
      tick();
      if (s_pop) begin
        npop++; n_cmp++; x = q.size() ? q.pop_front() : 'x;
        if (s_out !== x) begin n_bad++; $display("FAIL bubble_pop got %h exp %h", s_out, x); end
      end
      if (s_acc) q.push_back(stored(e[c], b[c]));
    end
    n_cmp++;
    if (npop != 2) begin n_bad++; $display("FAIL bubble_count got %0d exp 2", npop); end
  endtask

  task automatic test_req_two();
    ent_t x;
    int idx = 0, npop = 0;
    dn.ready = 1'b0;
    for (int c = 0; c < 10 && idx < CAP; c++) begin
      drive(mk(32'h3100 + 32'(idx * 4)), 1'b1);
      tick();
      if (s_acc) idx++;
    end
    up.valid = 1'b0;
    n_cmp++;
    if (occ !== 2'(CAP)) begin n_bad++; $display("FAIL req_fill got occ=%0d exp %0d", occ, CAP); end
    req = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++;
    if ({dn.valid, occ} !== 3'b101 || cur() !== VEC) begin
      n_bad++; $display("FAIL req_two got v=%b occ=%0d ent=%h exp v=1 occ=1 ent=%h", dn.valid, occ, cur(), VEC);
    end
    q.push_back(VEC);
    dn.ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (s_pop) begin
        npop++; n_cmp++; x = q.size() ? q.pop_front() : 'x;
        if (s_out !== x) begin n_bad++; $display("FAIL req_two_pop got %h exp %h", s_out, x); end
      end
    end
    n_cmp++;
    if (npop != 1 || dn.valid !== 1'b0) begin
      n_bad++; $display("FAIL req_two_drain got pops=%0d v=%b exp pops=1 v=0", npop, dn.valid);
    end
  endtask

  task automatic test_req_accept();
    ent_t x;
    int npop = 0;
    dn.ready = 1'b1;
    drive(mk(32'h3020), 1'b1); bubble = 1'b1; req = 1'b1;
    tick();
    req = 1'b0; up.valid = 1'b0; bubble = 1'b0;
    n_cmp++;
    if (dn.valid !== 1'b1 || cur() !== VEC) begin
      n_bad++; $display("FAIL req_accept got v=%b ent=%h exp v=1 ent=%h", dn.valid, cur(), VEC);
    end
    q.push_back(VEC);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (s_pop) begin
        npop++; n_cmp++; x = q.size() ? q.pop_front() : 'x;
        if (s_out !== x) begin n_bad++; $display("FAIL req_accept_pop got %h exp %h", s_out, x); end
      end
    end
    n_cmp++;
    if (npop != 1) begin n_bad++; $display("FAIL req_accept_count got %0d exp 1", npop); end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    dn.ready = 1'b0;
    for (int c = 0; c < 10 && idx < CAP; c++) begin
      drive(mk(32'h3200 + 32'(idx * 4)), 1'b1);
      tick();
      if (s_acc) idx++;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({dn.valid, up.ready, occ} !== 4'b0100 || cur() !== RST) begin
      n_bad++; $display("FAIL reset_mid got v=%b rdy=%b occ=%0d ent=%h exp v=0 rdy=1 occ=0 ent=%h",
                        dn.valid, up.ready, occ, cur(), RST);
    end
    up.valid = 1'b0;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    ent_t e[40], x;
    logic b[40];
    int idx = 0, npop = 0;
    for (int i = 0; i < 40; i++) begin
      e[i] = mk(32'h5000 + 32'(i * 4));
      e[i].bd = 1'($urandom_range(0, 1));
      e[i].exc = 5'($urandom_range(0, 31));
      b[i] = $urandom_range(0, 4) == 0;
    end
    for (int c = 0; c < 400 && (idx < 40 || q.size() > 0); c++) begin
      dn.ready = $urandom_range(0, 9) < 7;
      if (idx < 40 && $urandom_range(0, 9) < 7) begin drive(e[idx], 1'b1); bubble = b[idx]; end
      else begin up.valid = 1'b0; bubble = 1'b0; end
      tick();
      if (s_pop) begin
        npop++; n_cmp++; x = q.size() ? q.pop_front() : 'x;
        if (s_out !== x) begin n_bad++; $display("FAIL b2b_pop got %h exp %h", s_out, x); end
      end
      if (s_acc) begin q.push_back(stored(e[idx], b[idx])); idx++; end
    end
    up.valid = 1'b0;
    n_cmp++;
    if (npop != 40 || q.size() != 0) begin
      n_bad++; $display("FAIL b2b_count got pops=%0d left=%0d exp pops=40 left=0", npop, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_req_two();
    test_req_accept();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
